// File: rtl/pdm_playback_if.sv
// PCM sample stream into the PDM playback modulator: a plain valid/ready
// handshake. The producer drives the master side, the modulator is the slave.
interface pdm_playback_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] pcm_in;
  logic                  pcm_valid;
  logic                  pcm_ready;

  modport master (
    output pcm_in,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_in,
    input  pcm_valid,
    output pcm_ready
  );
endinterface

// File: rtl/pdm_playback_modulator.sv
// PDM playback modulator: signed PCM samples are buffered in a small FIFO,
// zero-order-held for INTERP_FACTOR PDM bits each, and noise-shaped by a
// first-order error-feedback sigma-delta accumulator. Drives the PDM bit
// clock and data for a PDM speaker/DAC. Data changes on the pdm_clk falling
// edge so it is stable around every rising edge seen by the device.
module pdm_playback_modulator #(
  parameter int DATA_WIDTH    = 16,
  parameter int INTERP_FACTOR = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int CLK_FREQ      = 100_000_000,
  parameter int PDM_CLK_FREQ  = 2_822_400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  pdm_playback_if.slave pcm,
  output logic          pdm_clk,
  output logic          pdm_out,
  output logic          underrun
);

  // System clocks per PDM bit, and the length of the high phase.
  localparam int P        = CLK_FREQ / PDM_CLK_FREQ;
  localparam int HALF     = P / 2;
  localparam int DIV_W    = $clog2(P);
  localparam int INTERP_W = $clog2(INTERP_FACTOR);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  // Signed two's complement to offset binary: flipping the MSB maps
  // -2^(N-1)..2^(N-1)-1 onto 0..2^N-1, which is the ones density numerator.
  function automatic logic [DATA_WIDTH-1:0] to_offset_binary(input logic [DATA_WIDTH-1:0] s);
    return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
  endfunction

  // Registers
  logic [DIV_W-1:0]      div_cnt_r;
  logic [INTERP_W-1:0]   interp_cnt_r;
  logic [DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0] cur_sample_r;
  logic                  pdm_clk_r;
  logic                  pdm_out_r;
  logic                  underrun_r;
  logic                  pcm_ready_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  // Combinational signals
  logic [DIV_W-1:0]      div_next_s;
  logic                  tick_s;
  logic                  load_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      count_next_s;
  logic [DATA_WIDTH-1:0] mod_sample_s;
  logic [DATA_WIDTH:0]   sum_s;

  assign pcm.pcm_ready = pcm_ready_r;
  assign pdm_clk       = pdm_clk_r;
  assign pdm_out       = pdm_out_r;
  assign underrun      = underrun_r;

  // Bit tick lands on the edge that drives pdm_clk low; a load tick is the
  // first bit of each held sample.
  assign tick_s  = enable & (div_cnt_r == DIV_W'(HALF - 1));
  assign load_s  = tick_s & (interp_cnt_r == {INTERP_W{1'b0}});
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = pcm.pcm_valid & pcm_ready_r;
  assign pop_s   = load_s & ~empty_s;

  // Next divider count: free-running 0..P-1 while enabled, parked at 0 otherwise.
  always_comb begin
    div_next_s = {DIV_W{1'b0}};
    if (enable) begin
      if (div_cnt_r == DIV_W'(P - 1)) begin
        div_next_s = {DIV_W{1'b0}};
      end else begin
        div_next_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      div_next_s = {DIV_W{1'b0}};
    end
  end

  // FIFO occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Sample feeding the modulator this tick: a freshly popped head is used
  // immediately so the load tick's bit already reflects the new sample.
  always_comb begin
    mod_sample_s = cur_sample_r;
    if (pop_s) begin
      mod_sample_s = fifo_mem_r[rd_ptr_r];
    end else begin
      mod_sample_s = cur_sample_r;
    end
    sum_s = {1'b0, acc_r} + {1'b0, to_offset_binary(mod_sample_s)};
  end

  // Bit clock generation: pdm_clk mirrors (div_cnt < P/2) of the new count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      pdm_clk_r <= 1'b0;
    end else begin
      div_cnt_r <= div_next_s;
      if (enable) begin
        pdm_clk_r <= (div_next_s < DIV_W'(HALF));
      end else begin
        pdm_clk_r <= 1'b0;
      end
    end
  end

  // Sigma-delta modulator, interpolation counter, sample hold and underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= {DATA_WIDTH{1'b0}};
      interp_cnt_r <= {INTERP_W{1'b0}};
      cur_sample_r <= {DATA_WIDTH{1'b0}};
      pdm_out_r    <= 1'b0;
      underrun_r   <= 1'b0;
    end else if (!enable) begin
      // Partial sample is abandoned; the held sample itself is kept.
      acc_r        <= {DATA_WIDTH{1'b0}};
      interp_cnt_r <= {INTERP_W{1'b0}};
      pdm_out_r    <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      underrun_r <= load_s & empty_s;
      if (pop_s) begin
        cur_sample_r <= fifo_mem_r[rd_ptr_r];
      end else begin
        cur_sample_r <= cur_sample_r;
      end
      if (tick_s) begin
        acc_r     <= sum_s[DATA_WIDTH-1:0];
        pdm_out_r <= sum_s[DATA_WIDTH];
        if (interp_cnt_r == INTERP_W'(INTERP_FACTOR - 1)) begin
          interp_cnt_r <= {INTERP_W{1'b0}};
        end else begin
          interp_cnt_r <= interp_cnt_r + INTERP_W'(1);
        end
      end else begin
        acc_r        <= acc_r;
        pdm_out_r    <= pdm_out_r;
        interp_cnt_r <= interp_cnt_r;
      end
    end
  end

  // Sample FIFO; keeps running while disabled so a producer can pre-fill it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      pcm_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= pcm.pcm_in;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_next_s;
      pcm_ready_r <= (count_next_s < CNT_W'(FIFO_DEPTH));
    end
  end

endmodule
